// File: rtl/rtc_set_ctrl.sv
// rtc_set_ctrl: time-set controller for the real-time clock.
// A MODE/INC two-button FSM captures the running time into a shadow
// register, edits hours, minutes and seconds in turn, then commits the
// shadow value to the timer with a one-cycle LOAD pulse. While editing,
// the timer is held and the edited field blinks on the display.
module rtc_set_ctrl #(
  parameter int TIMEOUT_TICKS = 20,
  parameter int TO_W          = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BTN_MODE,
  input  logic        BTN_INC,
  input  logic        BLINK_TICK,
  input  logic [23:0] CUR_TIME,
  output logic [23:0] SET_TIME,
  output logic        LOAD,
  output logic        RUN_EN,
  output logic [23:0] DISP_TIME,
  output logic [5:0]  BLANK,
  output logic [1:0]  MODE_ST
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_TICKS);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  // Blank masks for the two digits of each editable field.
  localparam logic [5:0] BLANK_HR  = 6'b110000;
  localparam logic [5:0] BLANK_MIN = 6'b001100;
  localparam logic [5:0] BLANK_SEC = 6'b000011;

  state_t          state_q, state_d;
  logic [23:0]     set_time_q, set_time_d;
  logic            load_q, load_d;
  logic            run_en_q, run_en_d;
  logic            phase_q, phase_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [5:0]      blank_q, blank_d;
  logic            btn_mode_q;
  logic            btn_inc_q;

  logic            mode_press;
  logic            inc_raw_press;
  logic            inc_press;
  logic            any_press;
  logic            in_set;
  logic            timeout;

  // BCD hours increment 00..23 with wrap; any out-of-range value
  // (including a garbage capture) restarts the field at 00.
  function automatic logic [7:0] inc_hours(input logic [7:0] h);
    logic [3:0] hm;
    logic [3:0] hl;
    hm = h[7:4];
    hl = h[3:0];
    if ((hm > 4'd2) || (hl > 4'd9) || ((hm == 4'd2) && (hl >= 4'd3))) begin
      return 8'h00;
    end
    if (hl == 4'd9) begin
      return {hm + 4'd1, 4'd0};
    end
    return {hm, hl + 4'd1};
  endfunction

  // BCD minutes increment 00..59 with wrap and no carry out; invalid
  // digits restart the field at 00.
  function automatic logic [7:0] inc_minutes(input logic [7:0] m);
    logic [3:0] mm;
    logic [3:0] ml;
    mm = m[7:4];
    ml = m[3:0];
    if ((mm > 4'd5) || (ml > 4'd9)) begin
      return 8'h00;
    end
    if (ml == 4'd9) begin
      return {(mm == 4'd5) ? 4'd0 : (mm + 4'd1), 4'd0};
    end
    return {mm, ml + 4'd1};
  endfunction

  // Rising-edge press detection; MODE wins over a simultaneous INC.
  always_comb begin
    mode_press    = BTN_MODE & ~btn_mode_q;
    inc_raw_press = BTN_INC & ~btn_inc_q;
    inc_press     = inc_raw_press & ~mode_press;
    any_press     = mode_press | inc_raw_press;
    in_set        = (state_q != ST_RUN);
    timeout       = in_set && BLINK_TICK && ((to_cnt_q + TO_ONE) == TO_LIMIT);
  end

  // Next-state logic for the FSM, shadow register, timeout and blink.
  always_comb begin
    state_d    = state_q;
    set_time_d = set_time_q;
    load_d     = 1'b0;
    run_en_d   = run_en_q;
    phase_d    = phase_q;
    to_cnt_d   = to_cnt_q;
    blank_d    = 6'b000000;

    case (state_q)
      ST_RUN: begin
        if (mode_press) begin
          state_d    = ST_SET_HR;
          set_time_d = CUR_TIME;
          run_en_d   = 1'b0;
        end
      end
      ST_SET_HR: begin
        if (mode_press) begin
          state_d = ST_SET_MIN;
        end else if (inc_press) begin
          set_time_d[23:16] = inc_hours(set_time_q[23:16]);
        end else if (timeout) begin
          state_d  = ST_RUN;
          run_en_d = 1'b1;
        end
      end
      ST_SET_MIN: begin
        if (mode_press) begin
          state_d = ST_SET_SEC;
        end else if (inc_press) begin
          set_time_d[15:8] = inc_minutes(set_time_q[15:8]);
        end else if (timeout) begin
          state_d  = ST_RUN;
          run_en_d = 1'b1;
        end
      end
      ST_SET_SEC: begin
        if (mode_press) begin
          state_d  = ST_RUN;
          load_d   = 1'b1;
          run_en_d = 1'b1;
        end else if (inc_press) begin
          set_time_d[7:0] = 8'h00;
        end else if (timeout) begin
          state_d  = ST_RUN;
          run_en_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_RUN;
        run_en_d = 1'b1;
      end
    endcase

    // Timeout counter restarts on every press and on every state change.
    if (any_press || (state_d != state_q)) begin
      to_cnt_d = '0;
    end else if (in_set && BLINK_TICK) begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end

    // Blink phase: a press shows the field immediately; RUN never blinks.
    if (any_press || (state_d == ST_RUN)) begin
      phase_d = 1'b0;
    end else if (in_set && BLINK_TICK) begin
      phase_d = ~phase_q;
    end

    if (phase_d) begin
      case (state_d)
        ST_SET_HR:  blank_d = BLANK_HR;
        ST_SET_MIN: blank_d = BLANK_MIN;
        ST_SET_SEC: blank_d = BLANK_SEC;
        default:    blank_d = 6'b000000;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_RUN;
      set_time_q <= 24'h000000;
      load_q     <= 1'b0;
      run_en_q   <= 1'b1;
      phase_q    <= 1'b0;
      to_cnt_q   <= '0;
      blank_q    <= 6'b000000;
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_time_q <= set_time_d;
      load_q     <= load_d;
      run_en_q   <= run_en_d;
      phase_q    <= phase_d;
      to_cnt_q   <= to_cnt_d;
      blank_q    <= blank_d;
      btn_mode_q <= BTN_MODE;
      btn_inc_q  <= BTN_INC;
    end
  end

  // Display mux selects between registered sources only.
  always_comb begin
    DISP_TIME = (state_q == ST_RUN) ? CUR_TIME : set_time_q;
  end

  assign SET_TIME = set_time_q;
  assign LOAD     = load_q;
  assign RUN_EN   = run_en_q;
  assign BLANK    = blank_q;
  assign MODE_ST  = state_q;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Testbench for rtc_set_ctrl: scenario tasks with a queue-based scoreboard.
module tb_rtc_set_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BTN_MODE = 1'b0;
  logic        BTN_INC = 1'b0;
  logic        BLINK_TICK = 1'b0;
  logic [23:0] CUR_TIME = 24'h000000;
  logic [23:0] SET_TIME;
  logic        LOAD;
  logic        RUN_EN;
  logic [23:0] DISP_TIME;
  logic [5:0]  BLANK;
  logic [1:0]  MODE_ST;

  typedef struct packed {
    logic [1:0]  st;
    logic [23:0] tm;
    logic        ren;
    logic        ld;
    logic [5:0]  blk;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [33:0] obs_v;
  int          tests_run = 0;
  int          tests_failed = 0;

  rtc_set_ctrl #(.TIMEOUT_TICKS(20), .TO_W(8)) dut (
    .CLK(CLK), .RST(RST), .BTN_MODE(BTN_MODE), .BTN_INC(BTN_INC),
    .BLINK_TICK(BLINK_TICK), .CUR_TIME(CUR_TIME), .SET_TIME(SET_TIME),
    .LOAD(LOAD), .RUN_EN(RUN_EN), .DISP_TIME(DISP_TIME), .BLANK(BLANK),
    .MODE_ST(MODE_ST)
  );

  always #5 CLK = ~CLK;

  assign obs_v = {MODE_ST, SET_TIME, RUN_EN, LOAD, BLANK};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [1:0] st, input logic [23:0] tm,
                              input logic ren, input logic ld, input logic [5:0] blk);
    exp_t r;
    r.st = st; r.tm = tm; r.ren = ren; r.ld = ld; r.blk = blk;
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  // One released cycle, then one cycle with the requested buttons high.
  task automatic press(input logic m, input logic i);
    BTN_MODE = 1'b0; BTN_INC = 1'b0;
    clk1();
    BTN_MODE = m; BTN_INC = i;
    clk1();
    BTN_MODE = 1'b0; BTN_INC = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clk1(); clk1();
    RST = 1'b0;
    exp_q.push_back(mk(2'd0, 24'h000000, 1'b1, 1'b0, 6'b0));
    clk1();
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL reset_state: got %h want %h", obs_v, e); end
    for (int i = 0; i < 10; i++) begin
      CUR_TIME = 24'($urandom);
      exp_q.push_back(mk(2'd0, 24'h000000, 1'b1, 1'b0, 6'b0));
      clk1();
      e = exp_q.pop_front(); tests_run++;
      if (obs_v !== e) begin tests_failed++; $display("FAIL idle_state: got %h want %h", obs_v, e); end
    end
    tests_run++;
    if (DISP_TIME !== CUR_TIME) begin
      tests_failed++; $display("FAIL idle_disp: got %h want %h", DISP_TIME, CUR_TIME);
    end
  endtask

  task automatic test_set_hours();
    int h;
    CUR_TIME = 24'h235958;
    exp_q.push_back(mk(2'd1, 24'h235958, 1'b0, 1'b0, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL enter_set_hr: got %h want %h", obs_v, e); end
    CUR_TIME = 24'h000001;
    clk1();
    tests_run++;
    if (DISP_TIME !== 24'h235958) begin
      tests_failed++; $display("FAIL disp_in_set: got %h want %h", DISP_TIME, 24'h235958);
    end
    exp_q.push_back(mk(2'd1, 24'h005958, 1'b0, 1'b0, 6'b0));
    press(1'b0, 1'b1);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL hr_wrap_23: got %h want %h", obs_v, e); end
    h = 0;
    for (int i = 0; i < 10; i++) begin
      h = (h + 1) % 24;
      exp_q.push_back(mk(2'd1, {to_bcd(h), 16'h5958}, 1'b0, 1'b0, 6'b0));
      press(1'b0, 1'b1);
      e = exp_q.pop_front(); tests_run++;
      if (obs_v !== e) begin tests_failed++; $display("FAIL hr_inc: got %h want %h", obs_v, e); end
    end
  endtask

  task automatic test_minutes_and_load();
    exp_q.push_back(mk(2'd2, 24'h105958, 1'b0, 1'b0, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL enter_set_min: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd2, 24'h100058, 1'b0, 1'b0, 6'b0));
    press(1'b0, 1'b1);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL min_wrap_59: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd3, 24'h100058, 1'b0, 1'b0, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL enter_set_sec: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd3, 24'h100000, 1'b0, 1'b0, 6'b0));
    press(1'b0, 1'b1);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL sec_clear: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd0, 24'h100000, 1'b1, 1'b1, 6'b0));
    exp_q.push_back(mk(2'd0, 24'h100000, 1'b1, 1'b0, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL load_pulse: got %h want %h", obs_v, e); end
    clk1();
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL load_one_cycle: got %h want %h", obs_v, e); end
    tests_run++;
    if (DISP_TIME !== CUR_TIME) begin
      tests_failed++; $display("FAIL disp_after_load: got %h want %h", DISP_TIME, CUR_TIME);
    end
  endtask

  task automatic test_hold_and_simultaneous();
    CUR_TIME = 24'h075000;
    exp_q.push_back(mk(2'd1, 24'h075000, 1'b0, 1'b0, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL hold_enter: got %h want %h", obs_v, e); end
    clk1();
    BTN_INC = 1'b1;
    exp_q.push_back(mk(2'd1, 24'h085000, 1'b0, 1'b0, 6'b0));
    clk1();
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL hold_first: got %h want %h", obs_v, e); end
    for (int i = 0; i < 49; i++) clk1();
    exp_q.push_back(mk(2'd1, 24'h085000, 1'b0, 1'b0, 6'b0));
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL hold_single_inc: got %h want %h", obs_v, e); end
    BTN_INC = 1'b0;
    exp_q.push_back(mk(2'd2, 24'h085000, 1'b0, 1'b0, 6'b0));
    press(1'b1, 1'b1);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL mode_over_inc: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd3, 24'h085000, 1'b0, 1'b0, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL hold_to_sec: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd0, 24'h085000, 1'b1, 1'b1, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL hold_commit: got %h want %h", obs_v, e); end
  endtask

  task automatic test_timeout();
    CUR_TIME = 24'h124500;
    exp_q.push_back(mk(2'd1, 24'h124500, 1'b0, 1'b0, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL to_enter: got %h want %h", obs_v, e); end
    for (int k = 1; k <= 20; k++) begin
      if (k < 20) exp_q.push_back(mk(2'd1, 24'h124500, 1'b0, 1'b0, (k % 2 == 1) ? 6'b110000 : 6'b0));
      else        exp_q.push_back(mk(2'd0, 24'h124500, 1'b1, 1'b0, 6'b0));
      BLINK_TICK = 1'b1;
      clk1();
      BLINK_TICK = 1'b0;
      e = exp_q.pop_front(); tests_run++;
      if (obs_v !== e) begin tests_failed++; $display("FAIL to_tick%0d: got %h want %h", k, obs_v, e); end
      clk1();
    end
    exp_q.push_back(mk(2'd0, 24'h124500, 1'b1, 1'b0, 6'b0));
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL to_no_load: got %h want %h", obs_v, e); end
  endtask

  task automatic test_blink_press();
    exp_q.push_back(mk(2'd1, 24'h124500, 1'b0, 1'b0, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL blink_enter: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd1, 24'h124500, 1'b0, 1'b0, 6'b110000));
    BLINK_TICK = 1'b1; clk1(); BLINK_TICK = 1'b0;
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL blink_on: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd1, 24'h134500, 1'b0, 1'b0, 6'b0));
    press(1'b0, 1'b1);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL press_unblanks: got %h want %h", obs_v, e); end
    for (int k = 0; k < 19; k++) begin
      BLINK_TICK = 1'b1; clk1(); BLINK_TICK = 1'b0; clk1();
    end
    exp_q.push_back(mk(2'd1, 24'h134500, 1'b0, 1'b0, 6'b110000));
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL tick19_still_set: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd1, 24'h144500, 1'b0, 1'b0, 6'b0));
    BLINK_TICK = 1'b1; BTN_INC = 1'b1;
    clk1();
    BLINK_TICK = 1'b0; BTN_INC = 1'b0;
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL press_beats_timeout: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd1, 24'h144500, 1'b0, 1'b0, 6'b110000));
    BLINK_TICK = 1'b1; clk1(); BLINK_TICK = 1'b0;
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL to_cnt_cleared: got %h want %h", obs_v, e); end
  endtask

  task automatic test_reset_in_set();
    exp_q.push_back(mk(2'd2, 24'h144500, 1'b0, 1'b0, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL rst_pre_min: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd0, 24'h000000, 1'b1, 1'b0, 6'b0));
    RST = 1'b1; BTN_MODE = 1'b1;
    clk1();
    RST = 1'b0; BTN_MODE = 1'b0;
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL rst_in_set: got %h want %h", obs_v, e); end
  endtask

  task automatic test_invalid_capture();
    CUR_TIME = 24'h3F0000;
    exp_q.push_back(mk(2'd1, 24'h3F0000, 1'b0, 1'b0, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL inv_capture: got %h want %h", obs_v, e); end
    exp_q.push_back(mk(2'd1, 24'h000000, 1'b0, 1'b0, 6'b0));
    press(1'b0, 1'b1);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL inv_hours: got %h want %h", obs_v, e); end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    exp_q.push_back(mk(2'd0, 24'h000000, 1'b1, 1'b1, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL inv_commit: got %h want %h", obs_v, e); end
    CUR_TIME = 24'h196A00;
    press(1'b1, 1'b0);
    exp_q.push_back(mk(2'd1, 24'h206A00, 1'b0, 1'b0, 6'b0));
    press(1'b0, 1'b1);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL hr_19_to_20: got %h want %h", obs_v, e); end
    press(1'b1, 1'b0);
    exp_q.push_back(mk(2'd2, 24'h200000, 1'b0, 1'b0, 6'b0));
    press(1'b0, 1'b1);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL inv_minutes: got %h want %h", obs_v, e); end
    press(1'b1, 1'b0);
    exp_q.push_back(mk(2'd0, 24'h200000, 1'b1, 1'b1, 6'b0));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); tests_run++;
    if (obs_v !== e) begin tests_failed++; $display("FAIL inv_final_load: got %h want %h", obs_v, e); end
  endtask

  initial begin
    test_reset();
    test_set_hours();
    test_minutes_and_load();
    test_hold_and_simultaneous();
    test_timeout();
    test_blink_press();
    test_reset_in_set();
    test_invalid_capture();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rtc_set_ctrl.md
Name: rtc_set_ctrl

Overview:
Time-set controller for the real-time clock. A MODE/INC two-button FSM captures the running time into a shadow register and edits hours, then minutes, then seconds. It commits the result to the timer with a one-cycle LOAD pulse and holds the timer while editing. It also selects the digits sent to the seven-segment decoders and generates per-digit blink blanking for the field being edited.

Parameters:
TIMEOUT_TICKS, 20, number of BLINK_TICK pulses with no button press after which set mode aborts without loading (valid range 1..255).
TO_W, 8, width of the timeout counter.

Ports:
CLK  input  1  system clock; all state changes on rising edge
RST  input  1  synchronous, active-high reset
BTN_MODE  input  1  debounced, synchronized MODE button level
BTN_INC  input  1  debounced, synchronized INC button level
BLINK_TICK  input  1  single-cycle enable pulse, nominally 2 Hz
CUR_TIME  input  24  running BCD time from the timer
SET_TIME  output  24  shadow BCD time; value loaded into the timer
LOAD  output  1  one-cycle pulse; timer loads SET_TIME
RUN_EN  output  1  timer count enable; low while editing
DISP_TIME  output  24  BCD digits for the seven-segment decoders
BLANK  output  6  per-digit blank: [5]=HRM, [4]=HRL, [3]=MIN_M, [2]=MIN_L, [1]=SEC_M, [0]=SEC_L
MODE_ST  output  2  current state: 0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC

Behaviour:
- Digit packing for all 24-bit buses: [23:20]HRM, [19:16]HRL, [15:12]MIN_M, [11:8]MIN_L, [7:4]SEC_M, [3:0]SEC_L.
- Reset values:
  - state RUN, MODE_ST=0, LOAD=0, RUN_EN=1, BLANK=0, SET_TIME=0.
  - Blink phase 0, timeout counter 0, button history registers 0.
  - RST has priority over all other inputs.
- Press detection:
  - A press is BTN & ~BTN_q, where BTN_q is the previous-cycle level.
  - A press takes effect at the first rising edge that samples the button high; a held button gives exactly one press.
  - MODE and INC pressed in the same cycle: MODE is acted on, INC is ignored.
- FSM (all outputs registered):
  - RUN: INC ignored. MODE press -> SET_HR; SET_TIME <= CUR_TIME; RUN_EN <= 0.
  - SET_HR: MODE -> SET_MIN. INC -> increment hours.
  - SET_MIN: MODE -> SET_SEC. INC -> increment minutes.
  - SET_SEC: MODE -> RUN with LOAD=1 for exactly that one cycle; RUN_EN <= 1 on the same edge. INC -> seconds <= 00.
- Hours increment (BCD):
  - 23 -> 00.
  - HRL=9 -> HRM+1, HRL=0.
  - Otherwise HRL+1.
  - Invalid captured hours (HRM>2, HRL>9, or value >23) -> 00.
- Minutes increment:
  - MIN_L=9 -> MIN_L=0, then MIN_M=5 -> 0, otherwise MIN_M+1.
  - Invalid digits (MIN_M>5 or MIN_L>9) -> 00.
  - No carry into hours.
- Timeout:
  - Counter clears on state entry and on any press, and increments on BLINK_TICK in SET states.
  - When it reaches TIMEOUT_TICKS: -> RUN, no LOAD, RUN_EN <= 1, SET_TIME retained.
  - A press in the same cycle as the timeout has priority over the timeout.
- Blink:
  - Phase toggles on BLINK_TICK in SET states.
  - Phase forces to 0 on any press and on entry to RUN.
  - BLANK is asserted on the two digits of the edited field when phase=1; BLANK=0 in RUN.
- DISP_TIME:
  - CUR_TIME in RUN, SET_TIME in SET states.
  - Combinational mux of registered sources, valid in the same cycle as MODE_ST.
- LOAD is never asserted outside the SET_SEC->RUN transition.
- RST during a SET state: return to RUN with no LOAD.

Test Plan:
- Reset, then idle 10 cycles -> MODE_ST=0, RUN_EN=1, LOAD=0, BLANK=0, DISP_TIME follows CUR_TIME.
- CUR_TIME=0x235958, press MODE -> MODE_ST=1, RUN_EN=0, SET_TIME=0x235958. Press INC -> SET_TIME=0x005958. Press INC ×10 -> hours 10.
- From SET_MIN with minutes 59, press INC -> minutes 00 and hours unchanged. Press MODE, INC, MODE -> seconds 00, LOAD high exactly one cycle with SET_TIME=0x??0000 (hours unchanged), RUN_EN=1 on the same edge.
- Hold BTN_INC high 50 cycles in SET_HR -> exactly one increment. Raise MODE and INC on the same edge -> state advances, field unchanged.
- Enter SET_HR, apply 20 BLINK_TICKs with no press -> return to RUN with LOAD never asserted. BLANK[5:4] alternates 1/0 on successive ticks, and a press forces BLANK=0.
- Assert RST in SET_MIN -> next cycle MODE_ST=0, RUN_EN=1, LOAD=0, SET_TIME=0. Captured CUR_TIME=0x3F0000, INC in SET_HR -> hours 00.
